// File: rtl/filter_pkg.sv
// Shared types for the face-filter parameter controller: face packing, style and FSM encodings.
package filter_pkg;

  localparam int FACE_W  = 42;
  localparam int COORD_W = 7;

  typedef struct packed {
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic [COORD_W-1:0] eye_row1;
    logic [COORD_W-1:0] eye_col1;
    logic [COORD_W-1:0] eye_row2;
    logic [COORD_W-1:0] eye_col2;
  } face_t;

  typedef enum logic [1:0] {
    STYLE_0 = 2'd0,
    STYLE_1 = 2'd1,
    STYLE_2 = 2'd2,
    STYLE_3 = 2'd3
  } style_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_HOLD    = 2'd1,
    ST_COMMIT  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/filter_face_reg.sv
// One face slot: shadow register filled by detector beats, live register loaded at commit.
// Define FILTER_SMOOTH_EN to average new coordinates with the previous live ones.
module filter_face_reg
  import filter_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  wr_i,
  input  face_t wr_data_i,
  input  logic  commit_i,
  input  logic  load_i,
  input  face_t load_data_i,
`ifdef FILTER_SMOOTH_EN
  input  logic  drop_i,
`endif
  output face_t shadow_o,
  output logic  valid_o,
  output face_t live_o
);

  face_t shadow_q;
  face_t live_q;
  face_t live_d;
  logic  valid_q;

`ifdef FILTER_SMOOTH_EN
  // Set while this slot holds a face that was live in the previous frame.
  logic live_vld_q;

  function automatic logic [COORD_W-1:0] avg7(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b);
    logic [COORD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COORD_W:1];
  endfunction

  function automatic face_t avg_face(input face_t a, input face_t b);
    face_t r;
    r.pos_x    = avg7(a.pos_x,    b.pos_x);
    r.pos_y    = avg7(a.pos_y,    b.pos_y);
    r.eye_row1 = avg7(a.eye_row1, b.eye_row1);
    r.eye_col1 = avg7(a.eye_col1, b.eye_col1);
    r.eye_row2 = avg7(a.eye_row2, b.eye_row2);
    r.eye_col2 = avg7(a.eye_col2, b.eye_col2);
    return r;
  endfunction
`endif

  always_comb begin
    live_d = live_q;
    if (load_i) begin
`ifdef FILTER_SMOOTH_EN
      live_d = live_vld_q ? avg_face(live_q, load_data_i) : load_data_i;
`else
      live_d = load_data_i;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shadow_q   <= '0;
      valid_q    <= 1'b0;
      live_q     <= '0;
`ifdef FILTER_SMOOTH_EN
      live_vld_q <= 1'b0;
`endif
    end else begin
      if (wr_i) begin
        shadow_q <= wr_data_i;
        valid_q  <= 1'b1;
      end else if (commit_i) begin
        valid_q  <= 1'b0;
      end
      live_q <= live_d;
`ifdef FILTER_SMOOTH_EN
      if (commit_i) begin
        live_vld_q <= load_i;
      end else if (drop_i) begin
        live_vld_q <= 1'b0;
      end
`endif
    end
  end

  assign shadow_o = shadow_q;
  assign valid_o  = valid_q;
  assign live_o   = live_q;

endmodule

// File: rtl/filter_param_ctrl.sv
// Filter parameter controller: collects detector face beats, commits them at vsync, tracks style.
// Define FILTER_SMOOTH_EN to enable coordinate smoothing inside the face slots.
module filter_param_ctrl
  import filter_pkg::*;
#(
  parameter int MISS_FRAMES = 4,
  parameter int STYLE_RST   = 0
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iFRAME_START,
  input  logic              iKEY_STYLE,
  input  logic              iDET_VALID,
  output logic              oDET_READY,
  input  logic              iDET_IDX,
  input  logic              iDET_NULL,
  input  logic              iDET_LAST,
  input  logic [FACE_W-1:0] iDET_FACE,
  output logic [FACE_W-1:0] oFACE0,
  output logic [FACE_W-1:0] oFACE1,
  output logic [1:0]        oNUM,
  output logic [1:0]        oSTYLE,
  output logic              oFRAME_UPD
);

  localparam int                MISS_W     = $clog2(MISS_FRAMES + 1);
  localparam logic [MISS_W-1:0] MISS_MAX   = MISS_W'(MISS_FRAMES);
  localparam logic [MISS_W-1:0] MISS_LAST  = MISS_W'(MISS_FRAMES - 1);
  localparam style_t            STYLE_INIT = style_t'(STYLE_RST[1:0]);

  ctrl_state_t       state_q;
  logic              ready_q;
  logic              upd_q;
  logic [1:0]        num_q;
  style_t            style_q;
  style_t            pend_q;
  logic [MISS_W-1:0] miss_q;

  logic       xfer;
  logic       commit;
  logic       drop;
  logic [1:0] commit_num;
  face_t      det_face;
  face_t      shadow [2];
  face_t      live [2];
  face_t      load_data [2];
  logic [1:0] valid;
  logic [1:0] load;
  logic [1:0] wr;

  assign det_face = iDET_FACE;
  assign xfer     = iDET_VALID && ready_q;
  assign commit   = (state_q == ST_COMMIT);
  // The frame that makes miss_q reach MISS_FRAMES drops the live face count.
  assign drop     = (state_q == ST_COLLECT) && iFRAME_START && (miss_q == MISS_LAST);

  assign commit_num = (valid == 2'b11) ? 2'd2 : ((|valid) ? 2'd1 : 2'd0);

  // Valid faces are packed toward slot 0, so a lone slot-1 face lands in oFACE0.
  always_comb begin
    load[0]      = commit && (valid[0] || valid[1]);
    load[1]      = commit && valid[0] && valid[1];
    load_data[0] = valid[0] ? shadow[0] : shadow[1];
    load_data[1] = shadow[1];
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      assign wr[gi] = xfer && !iDET_NULL && (iDET_IDX == 1'(gi));

      filter_face_reg u_slot (
        .clk_i       (iCLK),
        .rst_ni      (iRST_N),
        .wr_i        (wr[gi]),
        .wr_data_i   (det_face),
        .commit_i    (commit),
        .load_i      (load[gi]),
        .load_data_i (load_data[gi]),
`ifdef FILTER_SMOOTH_EN
        .drop_i      (drop),
`endif
        .shadow_o    (shadow[gi]),
        .valid_o     (valid[gi]),
        .live_o      (live[gi])
      );
    end
  endgenerate

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= ST_COLLECT;
      ready_q <= 1'b1;
      upd_q   <= 1'b0;
      num_q   <= 2'd0;
      style_q <= STYLE_INIT;
      pend_q  <= STYLE_INIT;
      miss_q  <= '0;
    end else begin
      upd_q <= 1'b0;
      // A key press coinciding with vsync lands in pend_q after the old value was applied.
      if (iKEY_STYLE) begin
        pend_q <= style_t'(pend_q + 2'd1);
      end
      if (iFRAME_START) begin
        style_q <= pend_q;
      end
      case (state_q)
        ST_COLLECT: begin
          if (xfer && iDET_LAST) begin
            state_q <= ST_HOLD;
            ready_q <= 1'b0;
          end
          if (iFRAME_START && (miss_q != MISS_MAX)) begin
            miss_q <= miss_q + MISS_W'(1);
          end
          if (drop) begin
            num_q <= 2'd0;
            upd_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (iFRAME_START) begin
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          state_q <= ST_COLLECT;
          ready_q <= 1'b1;
          num_q   <= commit_num;
          upd_q   <= 1'b1;
          miss_q  <= '0;
        end
        default: begin
          state_q <= ST_COLLECT;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign oDET_READY = ready_q;
  assign oFACE0     = live[0];
  assign oFACE1     = live[1];
  assign oNUM       = num_q;
  assign oSTYLE     = style_q;
  assign oFRAME_UPD = upd_q;

endmodule

// File: tb/tb_filter_param_ctrl.sv
// Self-checking bench for filter_param_ctrl against a frame-level behavioural model.
`timescale 1ns/1ps
module tb_filter_param_ctrl;

  localparam int MISS    = 4;
  localparam int STYLE_R = 1;
`ifdef FILTER_SMOOTH_EN
  localparam bit SMOOTH = 1'b1;
`else
  localparam bit SMOOTH = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        fs    = 1'b0;
  logic        key   = 1'b0;
  logic        dv    = 1'b0;
  logic        didx  = 1'b0;
  logic        dnull = 1'b0;
  logic        dlast = 1'b0;
  logic [41:0] dface = '0;
  logic        ready;
  logic [41:0] face0;
  logic [41:0] face1;
  logic [1:0]  num;
  logic [1:0]  style;
  logic        upd;

  always #5 clk = ~clk;

  filter_param_ctrl #(.MISS_FRAMES(MISS), .STYLE_RST(STYLE_R)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iFRAME_START(fs), .iKEY_STYLE(key),
    .iDET_VALID(dv), .oDET_READY(ready), .iDET_IDX(didx), .iDET_NULL(dnull),
    .iDET_LAST(dlast), .iDET_FACE(dface), .oFACE0(face0), .oFACE1(face1),
    .oNUM(num), .oSTYLE(style), .oFRAME_UPD(upd)
  );

  int checks   = 0;
  int failures = 0;
  int upd_cnt  = 0;

  // Frame-level model: shadow faces, live faces, counters.
  logic [41:0] m_face [2];
  logic [41:0] sh [2];
  bit          sv [2];
  bit          m_lv [2];
  bit          m_hold;
  int          m_num, m_style, m_pend, m_miss, m_upd;

  always @(negedge clk) if (upd === 1'b1) upd_cnt++;

  function automatic logic [41:0] mk_face(input int px, input int py, input int r1,
                                           input int c1, input int r2, input int c2);
    return {7'(px), 7'(py), 7'(r1), 7'(c1), 7'(r2), 7'(c2)};
  endfunction

  function automatic logic [41:0] rnd_face();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[41:0];
  endfunction

  function automatic logic [41:0] smooth(input logic [41:0] o, input logic [41:0] n);
    logic [41:0] r;
    for (int f = 0; f < 6; f++)
      r[f*7 +: 7] = 7'((int'(o[f*7 +: 7]) + int'(n[f*7 +: 7])) / 2);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_face[i] = '0; sh[i] = '0; sv[i] = 0; m_lv[i] = 0;
    end
    m_hold = 0; m_num = 0; m_style = STYLE_R; m_pend = STYLE_R; m_miss = 0;
  endtask

  task automatic model_frame(input bit k);
    logic [41:0] lst [2];
    int n;
    n = 0;
    lst[0] = '0; lst[1] = '0;
    m_style = m_pend;
    if (k) m_pend = (m_pend + 1) % 4;
    if (m_hold) begin
      for (int i = 0; i < 2; i++) if (sv[i]) begin lst[n] = sh[i]; n++; end
      for (int j = 0; j < 2; j++) begin
        if (j < n) begin
          m_face[j] = (SMOOTH && m_lv[j]) ? smooth(m_face[j], lst[j]) : lst[j];
          m_lv[j] = 1;
        end else begin
          m_lv[j] = 0;
        end
      end
      m_num = n; sv[0] = 0; sv[1] = 0; m_miss = 0; m_hold = 0; m_upd++;
    end else if (m_miss < MISS) begin
      m_miss++;
      if (m_miss == MISS) begin
        m_num = 0; m_lv[0] = 0; m_lv[1] = 0; m_upd++;
      end
    end
  endtask

  task automatic do_reset();
    fs = 0; key = 0; dv = 0; dlast = 0; dnull = 0; rst_n = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    model_reset();
    upd_cnt = 0; m_upd = 0;
  endtask

  task automatic send_beat(input bit idx, input bit nul, input bit last, input logic [41:0] f);
    bit acc;
    acc = 0;
    dv = 1; didx = idx; dnull = nul; dlast = last; dface = f;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = (ready === 1'b1);
      @(negedge clk);
    end
    dv = 0; dlast = 0; dnull = 0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL beat_accept ready=%b required=1 within 20 cycles", ready);
    end else begin
      if (!nul) begin sh[idx] = f; sv[idx] = 1; end
      if (last) m_hold = 1;
    end
  endtask

  task automatic press_key();
    key = 1; @(negedge clk); key = 0;
    m_pend = (m_pend + 1) % 4;
  endtask

  task automatic do_frame(input bit k);
    fs = 1; key = k; @(negedge clk);
    fs = 0; key = 0; @(negedge clk); @(negedge clk);
    model_frame(k);
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    if (face0 !== 42'd0) begin failures++; $display("FAIL reset_face0 got=%h exp=0", face0); end
    if (face1 !== 42'd0) begin failures++; $display("FAIL reset_face1 got=%h exp=0", face1); end
    if (num !== 2'd0) begin failures++; $display("FAIL reset_num got=%0d exp=0", num); end
    if (style !== 2'(STYLE_R)) begin failures++; $display("FAIL reset_style got=%0d exp=%0d", style, STYLE_R); end
    if (upd !== 1'b0) begin failures++; $display("FAIL reset_upd got=%b exp=0", upd); end
    $display("test_reset: ready=%b num=%0d style=%0d", ready, num, style);
  endtask

  task automatic test_two_faces();
    send_beat(0, 0, 0, mk_face(10, 12, 0, 0, 0, 0));
    send_beat(1, 0, 1, mk_face(40, 12, 0, 0, 0, 0));
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL hold_ready got=%b exp=0", ready); end
    fs = 1; @(negedge clk); fs = 0;
    checks++;
    if (num !== 2'd0) begin failures++; $display("FAIL commit_early_num got=%0d exp=0", num); end
    @(negedge clk);
    model_frame(0);
    checks += 5;
    if (num !== 2'd2) begin failures++; $display("FAIL two_num got=%0d exp=2", num); end
    if (face0[41:35] !== 7'd10) begin failures++; $display("FAIL two_pos0 got=%0d exp=10", face0[41:35]); end
    if (face1[41:35] !== 7'd40) begin failures++; $display("FAIL two_pos1 got=%0d exp=40", face1[41:35]); end
    if (face0 !== m_face[0]) begin failures++; $display("FAIL two_face0 got=%h exp=%h", face0, m_face[0]); end
    if (face1 !== m_face[1]) begin failures++; $display("FAIL two_face1 got=%h exp=%h", face1, m_face[1]); end
    @(negedge clk);
    checks++;
    if (upd_cnt !== 1) begin failures++; $display("FAIL two_upd got=%0d exp=1", upd_cnt); end
    $display("test_two_faces: num=%0d face0=%h face1=%h", num, face0, face1);
  endtask

  task automatic test_null_last();
    logic [41:0] prev;
    prev = face0;
    send_beat(0, 1, 1, rnd_face());
    do_frame(0);
    checks += 3;
    if (num !== 2'd0) begin failures++; $display("FAIL null_num got=%0d exp=0", num); end
    if (face0 !== prev) begin failures++; $display("FAIL null_face0 got=%h exp=%h", face0, prev); end
    if (upd_cnt !== m_upd) begin failures++; $display("FAIL null_upd got=%0d exp=%0d", upd_cnt, m_upd); end
    $display("test_null_last: num=%0d face0=%h", num, face0);
  endtask

  task automatic test_miss();
    int base;
    send_beat(0, 0, 0, rnd_face());
    send_beat(1, 0, 1, rnd_face());
    do_frame(0);
    checks++;
    if (num !== 2'd2) begin failures++; $display("FAIL miss_pre_num got=%0d exp=2", num); end
    for (int i = 1; i <= 4; i++) begin
      base = upd_cnt;
      do_frame(0);
      checks += 3;
      if (num !== ((i < 4) ? 2'd2 : 2'd0)) begin failures++; $display("FAIL miss_num_%0d got=%0d exp=%0d", i, num, (i < 4) ? 2 : 0); end
      if ((upd_cnt - base) !== ((i < 4) ? 0 : 1)) begin failures++; $display("FAIL miss_upd_%0d got=%0d exp=%0d", i, upd_cnt - base, (i < 4) ? 0 : 1); end
      if (face0 !== m_face[0]) begin failures++; $display("FAIL miss_face0_%0d got=%h exp=%h", i, face0, m_face[0]); end
      $display("test_miss: frame %0d num=%0d", i, num);
    end
  endtask

  task automatic test_style();
    checks++;
    if (style !== 2'd1) begin failures++; $display("FAIL style_start got=%0d exp=1", style); end
    press_key(); @(negedge clk); press_key(); @(negedge clk);
    checks++;
    if (style !== 2'd1) begin failures++; $display("FAIL style_midframe got=%0d exp=1", style); end
    do_frame(0);
    checks++;
    if (style !== 2'd3) begin failures++; $display("FAIL style_apply got=%0d exp=3", style); end
    do_frame(1);
    checks++;
    if (style !== 2'd3) begin failures++; $display("FAIL style_coincide got=%0d exp=3", style); end
    do_frame(0);
    checks++;
    if (style !== 2'd0) begin failures++; $display("FAIL style_next got=%0d exp=0", style); end
    $display("test_style: style=%0d", style);
  endtask

  task automatic test_smooth_ready();
    logic [41:0] fb;
    int exp_x;
    send_beat(0, 1, 1, '0);
    do_frame(0);
    send_beat(0, 0, 1, mk_face(20, 5, 0, 0, 9, 9));
    do_frame(0);
    checks++;
    if (face0[41:35] !== 7'd20) begin failures++; $display("FAIL smooth_first got=%0d exp=20", face0[41:35]); end
    send_beat(0, 0, 1, mk_face(31, 7, 0, 0, 3, 4));
    do_frame(0);
    exp_x = SMOOTH ? 25 : 31;
    checks += 2;
    if (face0[41:35] !== 7'(exp_x)) begin failures++; $display("FAIL smooth_avg got=%0d exp=%0d", face0[41:35], exp_x); end
    if (face0 !== m_face[0]) begin failures++; $display("FAIL smooth_face0 got=%h exp=%h", face0, m_face[0]); end
    send_beat(0, 1, 1, '0);
    do_frame(0);
    send_beat(0, 0, 1, mk_face(31, 7, 0, 0, 3, 4));
    do_frame(0);
    checks++;
    if (face0[41:35] !== 7'd31) begin failures++; $display("FAIL smooth_fresh got=%0d exp=31", face0[41:35]); end
    // VALID held through HOLD and COMMIT
    send_beat(0, 0, 1, rnd_face());
    fb = rnd_face();
    dv = 1; didx = 0; dnull = 0; dlast = 0; dface = fb;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ready !== 1'b0) begin failures++; $display("FAIL hold_ready_%0d got=%b exp=0", i, ready); end
      @(negedge clk);
    end
    fs = 1; @(negedge clk); fs = 0;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL commit_ready got=%b exp=0", ready); end
    @(negedge clk);
    model_frame(0);
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL collect_ready got=%b exp=1", ready); end
    @(negedge clk);
    dv = 0;
    sh[0] = fb; sv[0] = 1;
    send_beat(1, 1, 1, '0);
    do_frame(0);
    checks += 2;
    if (num !== 2'd1) begin failures++; $display("FAIL held_num got=%0d exp=1", num); end
    if (face0 !== m_face[0]) begin failures++; $display("FAIL held_face0 got=%h exp=%h", face0, m_face[0]); end
    $display("test_smooth_ready: face0=%h num=%0d", face0, num);
  endtask

  task automatic test_slot1_and_fs_xfer();
    logic [41:0] fc;
    send_beat(1, 0, 1, rnd_face());
    do_frame(0);
    checks += 2;
    if (num !== 2'd1) begin failures++; $display("FAIL slot1_num got=%0d exp=1", num); end
    if (face0 !== m_face[0]) begin failures++; $display("FAIL slot1_face0 got=%h exp=%h", face0, m_face[0]); end
    fc = rnd_face();
    dv = 1; didx = 0; dnull = 0; dlast = 1; dface = fc; fs = 1;
    @(negedge clk);
    dv = 0; dlast = 0; fs = 0;
    model_frame(0);
    sh[0] = fc; sv[0] = 1; m_hold = 1;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL fsxfer_ready got=%b exp=0", ready); end
    do_frame(0);
    checks += 3;
    if (num !== 2'd1) begin failures++; $display("FAIL fsxfer_num got=%0d exp=1", num); end
    if (face0 !== m_face[0]) begin failures++; $display("FAIL fsxfer_face0 got=%h exp=%h", face0, m_face[0]); end
    if (upd_cnt !== m_upd) begin failures++; $display("FAIL fsxfer_upd got=%0d exp=%0d", upd_cnt, m_upd); end
    $display("test_slot1_and_fs_xfer: num=%0d face0=%h", num, face0);
  endtask

  task automatic test_random();
    int nb;
    bit k;
    for (int fr = 0; fr < 40; fr++) begin
      nb = $urandom_range(0, 3);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) press_key();
        send_beat(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  (b == nb - 1) && ($urandom_range(0, 4) != 0), rnd_face());
      end
      k = ($urandom_range(0, 3) == 0);
      do_frame(k);
      checks += 5;
      if (num !== 2'(m_num)) begin failures++; $display("FAIL rnd_num frame=%0d got=%0d exp=%0d", fr, num, m_num); end
      if (face0 !== m_face[0]) begin failures++; $display("FAIL rnd_face0 frame=%0d got=%h exp=%h", fr, face0, m_face[0]); end
      if (face1 !== m_face[1]) begin failures++; $display("FAIL rnd_face1 frame=%0d got=%h exp=%h", fr, face1, m_face[1]); end
      if (style !== 2'(m_style)) begin failures++; $display("FAIL rnd_style frame=%0d got=%0d exp=%0d", fr, style, m_style); end
      if (upd_cnt !== m_upd) begin failures++; $display("FAIL rnd_upd frame=%0d got=%0d exp=%0d", fr, upd_cnt, m_upd); end
      $display("frame %0d: beats=%0d num=%0d style=%0d face0=%h face1=%h", fr, nb, num, style, face0, face1);
    end
  endtask

  task automatic test_reset_mid();
    send_beat(0, 0, 0, mk_face(50, 50, 1, 2, 3, 4));
    send_beat(1, 0, 1, mk_face(60, 60, 1, 2, 3, 4));
    do_frame(0);
    send_beat(0, 0, 0, rnd_face());
    do_reset();
    checks += 5;
    if (face0 !== 42'd0) begin failures++; $display("FAIL rmid_face0 got=%h exp=0", face0); end
    if (face1 !== 42'd0) begin failures++; $display("FAIL rmid_face1 got=%h exp=0", face1); end
    if (num !== 2'd0) begin failures++; $display("FAIL rmid_num got=%0d exp=0", num); end
    if (style !== 2'(STYLE_R)) begin failures++; $display("FAIL rmid_style got=%0d exp=%0d", style, STYLE_R); end
    if (ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", ready); end
    send_beat(1, 1, 1, '0);
    do_frame(0);
    checks += 2;
    if (num !== 2'd0) begin failures++; $display("FAIL rmid_discard_num got=%0d exp=0", num); end
    if (face0 !== 42'd0) begin failures++; $display("FAIL rmid_discard_face0 got=%h exp=0", face0); end
    $display("test_reset_mid: num=%0d face0=%h style=%0d", num, face0, style);
  endtask

  initial begin
    model_reset();
    m_upd = 0;
    test_reset();
    test_two_faces();
    test_null_last();
    test_miss();
    test_style();
    test_smooth_ready();
    test_slot1_and_fs_xfer();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
